// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, ALU op enum, ID/EX control word and pipe-select encoding
package rv32i_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
  } alu_op_e;
  // a_sel: 0 rs1, 1 pc. b_sel: 0 rs2, 1 imm.
  // br_type: 0 none, 1 jal, 2 jalr, {1,funct3} conditional branch.
  // wb_sel: 0 alu, 1 memory, 2 pc+4.
  typedef struct packed {
    alu_op_e    alu_op;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [3:0] br_type;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb_sel;
  } ctrl_t;
  typedef enum logic [2:0] {
    SEL_NORMAL = 3'b001,
    SEL_FLUSH  = 3'b010,
    SEL_STALL  = 3'b100
  } pipe_sel_e;
  // alt is instr[30], already qualified by the caller for where it selects SUB/SRA
  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async reads, one sync write, x0 hardwired to zero
// Ports: clk, reset (async active-low), we/wa/wd write port, ra1/ra2 -> rd1/rd2 read ports.
// WB_BYPASS_EN: when defined, a read of the register being written this cycle returns wd.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem <= '{default: '0};
    else if (we && wa != '0) mem[wa] <= wd;
`ifdef WB_BYPASS_EN
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
`else
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
`endif
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, register read, immediate/control generation, ID/EX register, load-use detect
// Ports: clk, reset (async active-low); reg_mux_sel one-hot 001 load / 010 flush / 100 hold (else hold);
// pc_ID/inst_ID from IF/ID; wb_en/wb_rd/wb_data register-file write from WB;
// *_EX registered ID/EX outputs; hazard_stall combinational load-use request.
// WB_BYPASS_EN: enables write-first forwarding inside the register file.
module id_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  reg_mux_sel,
  input  logic [31:0] pc_ID,
  input  logic [31:0] inst_ID,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_EX,
  output logic [31:0] rs1_data_EX,
  output logic [31:0] rs2_data_EX,
  output logic [31:0] imm_EX,
  output logic [4:0]  rd_EX,
  output logic [15:0] ctrl_EX,
  output logic        illegal_EX,
  output logic        hazard_stall
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic [31:0] rs1_data, rs2_data, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic legal, uses_rs2;
  ctrl_t ctrl, ctrl_q;
  assign opcode = inst_ID[6:0];
  assign f3 = inst_ID[14:12];
  assign rs1 = inst_ID[19:15];
  assign rs2 = inst_ID[24:20];
  assign imm_i = {{20{inst_ID[31]}}, inst_ID[31:20]};
  assign imm_s = {{20{inst_ID[31]}}, inst_ID[31:25], inst_ID[11:7]};
  assign imm_b = {{19{inst_ID[31]}}, inst_ID[31], inst_ID[7], inst_ID[30:25], inst_ID[11:8], 1'b0};
  assign imm_u = {inst_ID[31:12], 12'b0};
  assign imm_j = {{11{inst_ID[31]}}, inst_ID[31], inst_ID[19:12], inst_ID[20], inst_ID[30:21], 1'b0};
  reg_file u_rf (
    .clk(clk), .reset(reset),
    .we(wb_en), .wa(wb_rd), .wd(wb_data),
    .ra1(rs1), .ra2(rs2), .rd1(rs1_data), .rd2(rs2_data)
  );
  always_comb begin
    ctrl = '0;
    imm = '0;
    legal = 1'b1;
    case (opcode)
      OP_LUI:    begin ctrl.alu_op = ALU_COPY_B; ctrl.b_sel = 1'b1; ctrl.reg_wr = 1'b1; imm = imm_u; end
      OP_AUIPC:  begin ctrl.a_sel = 2'd1; ctrl.b_sel = 1'b1; ctrl.reg_wr = 1'b1; imm = imm_u; end
      OP_JAL:    begin ctrl.a_sel = 2'd1; ctrl.b_sel = 1'b1; ctrl.br_type = 4'd1; ctrl.reg_wr = 1'b1; ctrl.wb_sel = 2'd2; imm = imm_j; end
      OP_JALR:   begin ctrl.b_sel = 1'b1; ctrl.br_type = 4'd2; ctrl.reg_wr = 1'b1; ctrl.wb_sel = 2'd2; imm = imm_i; end
      OP_BRANCH: begin ctrl.alu_op = ALU_SUB; ctrl.br_type = {1'b1, f3}; imm = imm_b; end
      OP_LOAD:   begin ctrl.b_sel = 1'b1; ctrl.reg_wr = 1'b1; ctrl.mem_rd = 1'b1; ctrl.wb_sel = 2'd1; imm = imm_i; end
      OP_STORE:  begin ctrl.b_sel = 1'b1; ctrl.mem_wr = 1'b1; imm = imm_s; end
      // only SRAI takes instr[30] as a modifier; ADDI never becomes SUB
      OP_IMM:    begin ctrl.alu_op = alu_of(f3, inst_ID[30] && f3 == 3'b101); ctrl.b_sel = 1'b1; ctrl.reg_wr = 1'b1; imm = imm_i; end
      OP_OP:     begin ctrl.alu_op = alu_of(f3, inst_ID[30]); ctrl.reg_wr = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end
  assign uses_rs2 = opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH;
  assign hazard_stall = ctrl_q.mem_rd && rd_EX != '0 && (rd_EX == rs1 || (uses_rs2 && rd_EX == rs2));
  assign ctrl_EX = ctrl_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset || reg_mux_sel == SEL_FLUSH) begin
      pc_EX <= '0;
      rs1_data_EX <= '0;
      rs2_data_EX <= '0;
      imm_EX <= '0;
      rd_EX <= '0;
      ctrl_q <= '0;
      illegal_EX <= 1'b0;
    end else if (reg_mux_sel == SEL_NORMAL) begin
      pc_EX <= pc_ID;
      rs1_data_EX <= rs1_data;
      rs2_data_EX <= rs2_data;
      imm_EX <= imm;
      rd_EX <= ctrl.reg_wr ? inst_ID[11:7] : '0;
      ctrl_q <= ctrl;
      illegal_EX <= !legal && inst_ID != '0;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table vectors, directed corner sequences and random stimulus against a reference model
module tb_id_stage;
  logic clk = 0, reset = 0;
  logic [2:0] reg_mux_sel = 3'b001;
  logic [31:0] pc_ID = 0, inst_ID = 0, wb_data = 0;
  logic wb_en = 0;
  logic [4:0] wb_rd = 0;
  logic [31:0] pc_EX, rs1_data_EX, rs2_data_EX, imm_EX;
  logic [4:0] rd_EX;
  logic [15:0] ctrl_EX;
  logic illegal_EX, hazard_stall;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  id_stage dut (
    .clk(clk), .reset(reset), .reg_mux_sel(reg_mux_sel), .pc_ID(pc_ID), .inst_ID(inst_ID),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_EX(pc_EX), .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX),
    .rd_EX(rd_EX), .ctrl_EX(ctrl_EX), .illegal_EX(illegal_EX), .hazard_stall(hazard_stall)
  );
  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0] rd;
    logic [15:0] ctrl;
    logic ill;
  } idex_t;
  typedef struct {
    logic [31:0] inst, imm;
    logic [4:0] rd;
    logic [15:0] ctrl;
    logic ill;
  } vec_t;
  idex_t m;
  logic [31:0] rf_m [32];
  logic haz_seen;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (alt && f3 == 0) return 1;
    if (alt && f3 == 5) return 7;
    return base[f3];
  endfunction
  function automatic idex_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    idex_t d;
    logic [3:0] alu = 0, br = 0;
    logic [1:0] a = 0, wb = 0;
    logic b = 0, wr = 0, mr = 0, mw = 0, ok = 1;
    int imm = 0;
    case (i[6:0])
      7'h37: begin alu = 10; b = 1; wr = 1; imm = int'(i[31:12]) * 4096; end
      7'h17: begin a = 1; b = 1; wr = 1; imm = int'(i[31:12]) * 4096; end
      7'h6f: begin a = 1; b = 1; br = 1; wr = 1; wb = 2; imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
      7'h67: begin b = 1; br = 2; wr = 1; wb = 2; imm = sx(i[31:20], 12); end
      7'h63: begin alu = 1; br = 8 + i[14:12]; imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); end
      7'h03: begin b = 1; wr = 1; mr = 1; wb = 1; imm = sx(i[31:20], 12); end
      7'h23: begin b = 1; mw = 1; imm = sx({i[31:25], i[11:7]}, 12); end
      7'h13: begin alu = alu_code(i[14:12], i[30] && i[14:12] == 5); b = 1; wr = 1; imm = sx(i[31:20], 12); end
      7'h33: begin alu = alu_code(i[14:12], i[30]); wr = 1; end
      default: ok = 0;
    endcase
    d.pc = pc;
    d.rs1 = 0;
    d.rs2 = 0;
    d.imm = imm;
    d.rd = wr ? i[11:7] : 5'd0;
    d.ctrl = ok ? {alu, a, b, br, wr, mr, mw, wb} : 16'd0;
    d.ill = !ok && i != 0;
    return d;
  endfunction
  function automatic logic [31:0] rv(input logic [4:0] r, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    if (r == 0) return 0;
`ifdef WB_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return rf_m[r];
  endfunction
  function automatic logic ref_haz(input logic [31:0] i);
    logic two = i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63;
    return m.ctrl[3] && m.rd != 0 && (m.rd == i[19:15] || (two && m.rd == i[24:20]));
  endfunction
  task automatic check_all();
    chk("pc_EX", pc_EX, m.pc);
    chk("rs1_data_EX", rs1_data_EX, m.rs1);
    chk("rs2_data_EX", rs2_data_EX, m.rs2);
    chk("imm_EX", imm_EX, m.imm);
    chk("rd_EX", {27'd0, rd_EX}, {27'd0, m.rd});
    chk("ctrl_EX", {16'd0, ctrl_EX}, {16'd0, m.ctrl});
    chk("illegal_EX", {31'd0, illegal_EX}, {31'd0, m.ill});
  endtask
  task automatic step(input logic [2:0] sel, input logic [31:0] inst, input logic [31:0] pc,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    idex_t d;
    reg_mux_sel = sel; inst_ID = inst; pc_ID = pc; wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    haz_seen = hazard_stall;
    chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, ref_haz(inst)});
    @(posedge clk);
    d = ref_dec(inst, pc);
    d.rs1 = rv(inst[19:15], we, wr, wd);
    d.rs2 = rv(inst[24:20], we, wr, wd);
    if (sel == 3'b010) m = '{default: '0};
    else if (sel == 3'b001) m = d;
    if (we && wr != 0) rf_m[wr] = wd;
    #1;
    check_all();
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_pc"}, pc_EX, 0);
    chk({tag, "_rs1"}, rs1_data_EX, 0);
    chk({tag, "_rs2"}, rs2_data_EX, 0);
    chk({tag, "_imm"}, imm_EX, 0);
    chk({tag, "_rd_ctrl_ill"}, {11'd0, rd_EX, ctrl_EX}, {illegal_EX ? 32'hFFFFFFFF : 32'd0});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tv [11];
    logic [31:0] keep_pc, keep_imm;
    logic [2:0] sels [8] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b111};
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    tv[0]  = '{32'h00500093, 32'h00000005, 5'd1, 16'h0210, 1'b0};
    tv[1]  = '{32'hFFFFFFFF, 32'h00000000, 5'd0, 16'h0000, 1'b1};
    tv[2]  = '{32'h00000000, 32'h00000000, 5'd0, 16'h0000, 1'b0};
    tv[3]  = '{32'h123452B7, 32'h12345000, 5'd5, 16'hA210, 1'b0};
    tv[4]  = '{32'h0000A103, 32'h00000000, 5'd2, 16'h0219, 1'b0};
    tv[5]  = '{32'h0020A423, 32'h00000008, 5'd0, 16'h0204, 1'b0};
    tv[6]  = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd0, 16'h1100, 1'b0};
    tv[7]  = '{32'h00310233, 32'h00000000, 5'd4, 16'h0010, 1'b0};
    tv[8]  = '{32'h407302B3, 32'h00000000, 5'd5, 16'h1010, 1'b0};
    tv[9]  = '{32'h008000EF, 32'h00000008, 5'd1, 16'h0632, 1'b0};
    tv[10] = '{32'h4030D093, 32'h00000403, 5'd1, 16'h7210, 1'b0};
    m = '{default: '0};
    for (int r = 0; r < 32; r++) rf_m[r] = 0;
    #12;
    zero_check("reset_init");
    chk("reset_hazard", {31'd0, hazard_stall}, 0);
    reset = 1;
    @(posedge clk); #1;
    for (int r = 1; r < 32; r++) step(3'b001, 0, 0, 1, 5'(r), $urandom());
    for (int k = 0; k < 11; k++) begin
      step(3'b001, tv[k].inst, 32'h1000 + 4 * k, 0, 0, 0);
      chk("tv_imm", imm_EX, tv[k].imm);
      chk("tv_rd", {27'd0, rd_EX}, {27'd0, tv[k].rd});
      chk("tv_ctrl", {16'd0, ctrl_EX}, {16'd0, tv[k].ctrl});
      chk("tv_illegal", {31'd0, illegal_EX}, {31'd0, tv[k].ill});
    end
    step(3'b001, 0, 0, 1, 5, 32'h55);
    step(3'b001, 32'h00028093, 32'h2000, 0, 0, 0);
    chk("x5_before_reset", rs1_data_EX, 32'h55);
    #3 reset = 0;
    #1 zero_check("reset_mid");
    m = '{default: '0};
    for (int r = 0; r < 32; r++) rf_m[r] = 0;
    #1 reset = 1;
    @(posedge clk); #1;
    step(3'b001, 32'h00028093, 32'h2004, 0, 0, 0);
    chk("x5_after_reset", rs1_data_EX, 0);
    step(3'b001, 0, 0, 1, 3, 32'h11);
    step(3'b001, 32'h00018093, 32'h3000, 1, 3, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    chk("wb_same_cycle", rs1_data_EX, 32'hDEADBEEF);
`else
    chk("wb_same_cycle", rs1_data_EX, 32'h11);
`endif
    step(3'b001, 32'h00018093, 32'h3004, 0, 0, 0);
    chk("wb_next_cycle", rs1_data_EX, 32'hDEADBEEF);
    step(3'b001, 0, 0, 1, 0, 32'h1234);
    step(3'b001, 32'h000000B3, 32'h3008, 0, 0, 0);
    chk("x0_rs1", rs1_data_EX, 0);
    chk("x0_rs2", rs2_data_EX, 0);
    step(3'b001, 32'h0000A103, 32'h4000, 0, 0, 0);
    step(3'b100, 32'h00310233, 32'h4004, 0, 0, 0);
    chk("haz_rs1", {31'd0, haz_seen}, 1);
    step(3'b100, 32'h00328233, 32'h4004, 0, 0, 0);
    chk("haz_nomatch", {31'd0, haz_seen}, 0);
    step(3'b100, 32'h00218233, 32'h4004, 0, 0, 0);
    chk("haz_rs2", {31'd0, haz_seen}, 1);
    step(3'b100, 32'h00218213, 32'h4004, 0, 0, 0);
    chk("haz_itype_rs2field", {31'd0, haz_seen}, 0);
    step(3'b001, 32'h0000A003, 32'h4008, 0, 0, 0);
    step(3'b100, 32'h00000233, 32'h400C, 0, 0, 0);
    chk("haz_rd0", {31'd0, haz_seen}, 0);
    step(3'b001, 32'h00310233, 32'h5000, 0, 0, 0);
    keep_pc = pc_EX;
    keep_imm = imm_EX;
    step(3'b100, 32'h123452B7, 32'h5004, 0, 0, 0);
    chk("stall1_pc", pc_EX, 32'h5000);
    step(3'b100, 32'h008000EF, 32'h5008, 0, 0, 0);
    chk("stall2_pc", pc_EX, keep_pc);
    chk("stall2_ctrl", {16'd0, ctrl_EX}, 32'h0010);
    step(3'b011, 32'h4030D093, 32'h500C, 0, 0, 0);
    chk("sel011_hold", pc_EX, 32'h5000);
    chk("sel011_imm", imm_EX, keep_imm);
    step(3'b010, 32'h123452B7, 32'h5010, 0, 0, 0);
    zero_check("flush");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r = $urandom();
      logic [31:0] inst = (n % 8 == 0) ? r : (n % 29 == 0) ? 32'd0 : {r[31:7], ops[$urandom_range(0, 8)]};
      step(sels[$urandom_range(0, 7)], inst, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
